csa_window_accumulator: RTL and testbench

Multi-pass scheduler for the carry-save reduction datapath. It time-shares one K-operand carry-save reduction plus final adder across a convolution window of arbitrary size (e.g. 9 or 25 taps with K=3). Operands arrive K per beat over a valid/ready stream. The block sequences the beats of each window, accumulates the partial sums, and presents one window sum per window on a valid/ready output with backpressure. It sits between the operand/weight-product fetch stage and the activation stage.

---
 rtl/csa_window_accumulator.sv | 106 ++++++++++
 tb/tb_csa_window_accumulator.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/csa_window_accumulator.sv
// csa_window_accumulator: time-shares one K-operand carry-save reduction across multi-beat windows and emits one sum per window.
// Ports: clk/rst_n (async active-low); clear aborts the current window; cfg_passes = beats per window, sampled on the first beat;
//   in_valid/in_ready/in_data carry K operands per beat; out_valid/out_ready/out_sum/out_ovf hold the window result; busy = window in progress.
module csa_window_accumulator #(
  parameter int W     = 4,
  parameter int K     = 3,
  parameter int P_MAX = 16,
  parameter int ACC_W = 10,
  parameter int PW    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [PW-1:0]    cfg_passes,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [K*W-1:0]   in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic             busy
);
  typedef enum logic {IDLE, ACC} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] cnt_q, cnt_d, n_q, n_d, n_eff;
  logic [ACC_W-1:0] acc_q, acc_d, sum_q, sum_d;
  logic ovf_q, ovf_d, oovf_q, oovf_d, ov_q, ov_d;
  logic [ACC_W:0] beat, total;
  logic last, accept, ovf_new;
  // Chain of 3:2 compressors folding one operand per stage, then a single carry-propagate add.
  function automatic logic [ACC_W:0] beat_sum(input logic [K*W-1:0] d);
    logic [ACC_W:0] s, c, op, t;
    s = '0;
    c = '0;
    for (int j = 0; j < K; j++) begin
      op = '0;
      op[W-1:0] = d[j*W +: W];
      t = s ^ c ^ op;
      c = ((s & c) | (s & op) | (c & op)) << 1;
      s = t;
    end
    return s + c;
  endfunction
  assign beat = beat_sum(in_data);
  assign n_eff = cfg_passes == '0 ? PW'(1) : (cfg_passes > PW'(P_MAX) ? PW'(P_MAX) : cfg_passes);
  assign last = state_q == IDLE ? n_eff == PW'(1) : cnt_q == n_q - PW'(1);
  // A last beat may only enter when the output register is free or being drained this cycle.
  assign in_ready = !clear && !(last && ov_q && !out_ready);
  assign accept = in_valid && in_ready;
  assign total = (state_q == IDLE ? '0 : {1'b0, acc_q}) + beat;
  assign ovf_new = (state_q == ACC && ovf_q) | total[ACC_W];
  assign out_valid = ov_q;
  assign out_sum = sum_q;
  assign out_ovf = oovf_q;
  assign busy = cnt_q != '0;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    n_d = n_q;
    acc_d = acc_q;
    ovf_d = ovf_q;
    sum_d = sum_q;
    oovf_d = oovf_q;
    ov_d = ov_q && !out_ready;
    if (clear) begin
      state_d = IDLE;
      cnt_d = '0;
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (accept && last) begin
      state_d = IDLE;
      cnt_d = '0;
      sum_d = total[ACC_W-1:0];
      oovf_d = ovf_new;
      ov_d = 1'b1;
    end else if (accept) begin
      state_d = ACC;
      cnt_d = cnt_q + PW'(1);
      acc_d = total[ACC_W-1:0];
      ovf_d = ovf_new;
      n_d = state_q == IDLE ? n_eff : n_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      n_q <= '0;
      acc_q <= '0;
      ovf_q <= 1'b0;
      sum_q <= '0;
      oovf_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      n_q <= n_d;
      acc_q <= acc_d;
      ovf_q <= ovf_d;
      sum_q <= sum_d;
      oovf_q <= oovf_d;
      ov_q <= ov_d;
    end
  end
endmodule

// File: tb/tb_csa_window_accumulator.sv
// tb_csa_window_accumulator: drives a 10-bit and a 9-bit accumulator with the same stream and checks both against a window-level model.
module tb_csa_window_accumulator;
  logic clk = 1'b0;
  logic rst_n, clear, in_valid, out_ready;
  logic [4:0] cfg_passes;
  logic [11:0] in_data;
  logic rdy0, rdy1, ov0, ov1, of0, of1, busy0, busy1;
  logic [9:0] sum0;
  logic [8:0] sum1;
  int errs = 0;
  int checks = 0;
  int m_cnt = 0;
  int m_n = 0;
  int m_sum = 0;
  int m_os = 0;
  bit m_ov = 0;
  typedef struct {
    logic [4:0] cfg;
    logic [11:0] d;
    int beats;
    int s10;
    bit o10;
    int s9;
    bit o9;
  } vec_t;
  vec_t tbl[9];
  always #5 clk = ~clk;
  csa_window_accumulator #(.W(4), .K(3), .P_MAX(16), .ACC_W(10), .PW(5)) dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .cfg_passes(cfg_passes), .in_valid(in_valid), .in_ready(rdy0),
    .in_data(in_data), .out_valid(ov0), .out_ready(out_ready), .out_sum(sum0), .out_ovf(of0), .busy(busy0));
  csa_window_accumulator #(.W(4), .K(3), .P_MAX(16), .ACC_W(9), .PW(5)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .cfg_passes(cfg_passes), .in_valid(in_valid), .in_ready(rdy1),
    .in_data(in_data), .out_valid(ov1), .out_ready(out_ready), .out_sum(sum1), .out_ovf(of1), .busy(busy1));
  function automatic int clampn(input int c);
    return c == 0 ? 1 : (c > 16 ? 16 : c);
  endfunction
  function automatic int bsum(input logic [11:0] d);
    return int'(d[3:0]) + int'(d[7:4]) + int'(d[11:8]);
  endfunction
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic mreset();
    m_cnt = 0;
    m_n = 0;
    m_sum = 0;
    m_os = 0;
    m_ov = 0;
  endtask
  // One clock cycle: apply inputs, compare everything to the model, then advance the model by the edge.
  task automatic step(input logic v, input logic [11:0] d, input logic [4:0] cfg, input logic ordy, input logic clr);
    int n;
    bit last, rdy, acc;
    in_valid = v;
    in_data = d;
    cfg_passes = cfg;
    out_ready = ordy;
    clear = clr;
    #1;
    n = m_cnt == 0 ? clampn(int'(cfg)) : m_n;
    last = m_cnt + 1 == n;
    rdy = !clr && !(last && m_ov && !ordy);
    chk("in_ready", rdy0, rdy);
    chk("in_ready9", rdy1, rdy);
    chk("out_valid", ov0, m_ov);
    chk("out_valid9", ov1, m_ov);
    chk("busy", busy0, m_cnt != 0);
    chk("busy9", busy1, m_cnt != 0);
    chk("out_sum", sum0, m_os % 1024);
    chk("out_sum9", sum1, m_os % 512);
    chk("out_ovf", of0, m_os > 1023);
    chk("out_ovf9", of1, m_os > 511);
    @(posedge clk);
    acc = v && rdy;
    if (m_ov && ordy) m_ov = 0;
    if (clr) begin
      m_cnt = 0;
      m_sum = 0;
    end else if (acc) begin
      if (m_cnt == 0) begin
        m_n = n;
        m_sum = 0;
      end
      m_sum += bsum(d);
      if (last) begin
        m_os = m_sum;
        m_ov = 1;
        m_cnt = 0;
      end else m_cnt++;
    end
    @(negedge clk);
  endtask
  initial begin
    tbl[0] = '{5'd16, 12'hFFF, 16, 720, 0, 208, 1};
    tbl[1] = '{5'd0,  12'h321, 1,  6,   0, 6,   0};
    tbl[2] = '{5'd31, 12'hFFF, 16, 720, 0, 208, 1};
    tbl[3] = '{5'd1,  12'hFFF, 1,  45,  0, 45,  0};
    tbl[4] = '{5'd5,  12'h222, 5,  30,  0, 30,  0};
    tbl[5] = '{5'd12, 12'hF0F, 12, 360, 0, 360, 0};
    tbl[6] = '{5'd17, 12'hAAA, 16, 480, 0, 480, 0};
    tbl[7] = '{5'd16, 12'hEFF, 16, 704, 0, 192, 1};
    tbl[8] = '{5'd7,  12'h987, 7,  168, 0, 168, 0};
    rst_n = 1'b0;
    clear = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    cfg_passes = '0;
    in_data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // Basic 3-beat window.
    step(1, 12'h321, 5'd3, 1, 0);
    step(1, 12'h654, 5'd3, 1, 0);
    step(1, 12'h987, 5'd3, 1, 0);
    chk("w3_valid", ov0, 1);
    chk("w3_sum", sum0, 45);
    chk("w3_ovf", of0, 0);
    step(0, 12'h000, 5'd3, 1, 0);
    chk("w3_pulse", ov0, 0);
    // Table of windows, drained every cycle.
    for (int i = 0; i < 9; i++) begin
      for (int b = 0; b < tbl[i].beats; b++) step(1, tbl[i].d, tbl[i].cfg, 1, 0);
      chk("tbl_valid", ov0, 1);
      chk("tbl_sum10", sum0, tbl[i].s10);
      chk("tbl_ovf10", of0, tbl[i].o10);
      chk("tbl_sum9", sum1, tbl[i].s9);
      chk("tbl_ovf9", of1, tbl[i].o9);
    end
    step(0, 12'h000, 5'd1, 1, 0);
    // Backpressure with single-beat windows.
    step(1, 12'h111, 5'd1, 0, 0);
    step(1, 12'h111, 5'd1, 0, 0);
    chk("bp_ready", rdy0, 0);
    chk("bp_hold", sum0, 3);
    step(1, 12'h111, 5'd1, 1, 0);
    chk("bp_valid", ov0, 1);
    chk("bp_sum", sum0, 3);
    step(0, 12'h000, 5'd1, 1, 0);
    // Clear mid-window with a pending result.
    step(1, 12'h007, 5'd1, 0, 0);
    step(1, 12'h555, 5'd3, 0, 0);
    step(1, 12'h555, 5'd3, 0, 0);
    step(1, 12'h555, 5'd3, 0, 1);
    chk("clr_valid", ov0, 1);
    chk("clr_sum", sum0, 7);
    chk("clr_busy", busy0, 0);
    step(1, 12'h001, 5'd3, 1, 0);
    step(1, 12'h001, 5'd3, 1, 0);
    step(1, 12'h001, 5'd3, 1, 0);
    chk("clr_next_sum", sum0, 3);
    step(0, 12'h000, 5'd3, 1, 0);
    // Asynchronous reset with a pending result and a window in progress.
    step(1, 12'hFFF, 5'd1, 0, 0);
    step(1, 12'h111, 5'd4, 0, 0);
    step(1, 12'h111, 5'd4, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", ov0, 0);
    chk("rst_sum", sum0, 0);
    chk("rst_ovf", of0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_valid9", ov1, 0);
    mreset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int b = 0; b < 4; b++) step(1, 12'h111, 5'd4, 1, 0);
    chk("rst_win_sum", sum0, 12);
    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] c;
      c = $urandom_range(0, 9) == 0 ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
      step($urandom_range(0, 3) != 0, 12'($urandom), c, $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
